// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the nibble-serial 74181 sequencer
package alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_LOAD = 2'd0,
      ST_EXEC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [2:0] IDX_CTRL = 3'd0;
   localparam logic [2:0] IDX_ALO  = 3'd1;
   localparam logic [2:0] IDX_AHI  = 3'd2;
   localparam logic [2:0] IDX_BLO  = 3'd3;
   localparam logic [2:0] IDX_BHI  = 3'd4;

   localparam logic [1:0] NIB_LAST = 2'd3;

   localparam int UIO_BUSY   = 2;
   localparam int UIO_DONE   = 3;
   localparam int UIO_COUT_N = 4;
   localparam int UIO_EQL    = 5;
   localparam int UIO_ZERO   = 6;

   localparam logic [7:0] UIO_OE = 8'b0111_1100;

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - tile pin bundle between the switch/LED side and the sequencer
interface alu_seq_if;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
   modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/ALU74181.sv
// rtl/ALU74181.sv - combinational 74181 4-bit ALU slice, active-high data, active-low carries
module ALU74181 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [3:0] s,
   input  logic       m,
   input  logic       notc,
   output logic [3:0] f,
   output logic       eql,
   output logic       cout,
   output logic       pout,
   output logic       gout
);
   logic [3:0] p_n;
   logic [3:0] g_n;
   logic [3:0] prop;
   logic [3:0] gen;
   logic [3:0] c_in;
   logic       c1;
   logic       c2;
   logic       c3;
   logic       c4;

   // First-level gate pair of the slice; s selects how b feeds each term
   assign p_n  = ~(a | (b & {4{s[0]}}) | (~b & {4{s[1]}}));
   assign g_n  = ~((a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}}));
   assign prop = ~p_n;
   assign gen  = ~g_n;

   assign c1 = gen[0] | (prop[0] & ~notc);
   assign c2 = gen[1] | (prop[1] & c1);
   assign c3 = gen[2] | (prop[2] & c2);
   assign c4 = gen[3] | (prop[3] & c3);
   assign c_in = {c3, c2, c1, ~notc};

   // m=1 masks the carry terms so f is a pure bitwise function
   assign f    = ~(p_n ^ g_n) ^ ({4{~m}} & ~c_in);
   assign eql  = &f;
   assign cout = ~c4;
   assign pout = ~&prop;
   assign gout = ~(gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
                   | (prop[3] & prop[2] & prop[1] & gen[0]));
endmodule

// File: rtl/tt_um_guidoism_alu_seq.sv
// rtl/tt_um_guidoism_alu_seq.sv - loads control + two 16-bit operands, runs one 74181 over four nibbles
module tt_um_guidoism_alu_seq
   import alu_seq_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  logic     ena,
   alu_seq_if.slave bus
);
   state_t      state_q;
   state_t      state_d;
   logic [2:0]  sync_q;
   logic        strobe_edge;
   logic [2:0]  byte_idx_q;
   logic [1:0]  nib_q;
   logic [3:0]  s_q;
   logic        m_q;
   logic        cn_n_q;
   logic [15:0] a_q;
   logic [15:0] b_q;
   logic [15:0] result_q;
   logic [15:0] result_nxt;
   logic        carry_q;
   logic        eql_acc_q;
   logic        cout_n_q;
   logic        eql_q;
   logic        zero_q;
   logic        busy;
   logic        done;
   logic [7:0]  uio_out_d;
   logic [3:0]  slice_f;
   logic        slice_eql;
   logic        slice_cout;
   logic        slice_pout;
   logic        slice_gout;
   logic        unused_bits;

   // Two flops resynchronise the strobe, the third remembers its previous level
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= 3'b000;
      else        sync_q <= {sync_q[1:0], bus.uio_in[0]};
   end
   assign strobe_edge = sync_q[1] & ~sync_q[2];

   always_ff @(posedge clk) begin
      if (!rst_n)   state_q <= ST_LOAD;
      else if (ena) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD: if (strobe_edge && byte_idx_q == IDX_BHI) state_d = ST_EXEC;
         ST_EXEC: if (nib_q == NIB_LAST)                    state_d = ST_DONE;
         ST_DONE: if (strobe_edge)                          state_d = ST_LOAD;
         default:                                           state_d = ST_LOAD;
      endcase
   end

   always_comb begin
      busy = (state_q == ST_EXEC);
      done = (state_q == ST_DONE);
   end

   ALU74181 u_slice (
      .a    (a_q[{nib_q, 2'b00} +: 4]),
      .b    (b_q[{nib_q, 2'b00} +: 4]),
      .s    (s_q),
      .m    (m_q),
      .notc (carry_q),
      .f    (slice_f),
      .eql  (slice_eql),
      .cout (slice_cout),
      .pout (slice_pout),
      .gout (slice_gout)
   );

   always_comb begin
      result_nxt = result_q;
      result_nxt[{nib_q, 2'b00} +: 4] = slice_f;
   end

   // DONE leaves byte_idx_q at IDX_CTRL, so loading restarts there without a special case
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_idx_q <= IDX_CTRL;
         nib_q      <= 2'd0;
         s_q        <= 4'h0;
         m_q        <= 1'b0;
         cn_n_q     <= 1'b0;
         a_q        <= 16'h0000;
         b_q        <= 16'h0000;
         result_q   <= 16'h0000;
         carry_q    <= 1'b0;
         eql_acc_q  <= 1'b0;
         cout_n_q   <= 1'b0;
         eql_q      <= 1'b0;
         zero_q     <= 1'b0;
      end else if (ena) begin
         if (state_q == ST_EXEC) begin
            result_q  <= result_nxt;
            carry_q   <= slice_cout;
            eql_acc_q <= eql_acc_q & slice_eql;
            nib_q     <= nib_q + 2'd1;
            if (nib_q == NIB_LAST) begin
               cout_n_q <= slice_cout;
               eql_q    <= eql_acc_q & slice_eql;
               zero_q   <= (result_nxt == 16'h0000);
            end
         end else if (strobe_edge) begin
            case (byte_idx_q)
               IDX_CTRL: begin
                  cn_n_q <= bus.ui_in[5];
                  m_q    <= bus.ui_in[4];
                  s_q    <= bus.ui_in[3:0];
               end
               IDX_ALO: a_q[7:0]  <= bus.ui_in;
               IDX_AHI: a_q[15:8] <= bus.ui_in;
               IDX_BLO: b_q[7:0]  <= bus.ui_in;
               IDX_BHI: b_q[15:8] <= bus.ui_in;
               default: ;
            endcase
            if (byte_idx_q == IDX_BHI) begin
               byte_idx_q <= IDX_CTRL;
               nib_q      <= 2'd0;
               carry_q    <= cn_n_q;
               eql_acc_q  <= 1'b1;
            end else begin
               byte_idx_q <= byte_idx_q + 3'd1;
            end
         end
      end
   end

   always_comb begin
      uio_out_d             = 8'h00;
      uio_out_d[UIO_BUSY]   = busy;
      uio_out_d[UIO_DONE]   = done;
      uio_out_d[UIO_COUT_N] = cout_n_q;
      uio_out_d[UIO_EQL]    = eql_q;
      uio_out_d[UIO_ZERO]   = zero_q;
   end

   assign bus.uio_out = uio_out_d;
   assign bus.uio_oe  = UIO_OE;
   assign bus.uo_out  = bus.uio_in[1] ? result_q[15:8] : result_q[7:0];

   assign unused_bits = ^{bus.uio_in[7:2], bus.ui_in[7:6], slice_pout, slice_gout};
endmodule

// File: tb/tb_tt_um_guidoism_alu_seq.sv
// tb/tb_tt_um_guidoism_alu_seq.sv - scoreboard bench for the nibble-serial 74181 sequencer
module tb_tt_um_guidoism_alu_seq;
   typedef struct {
      logic [15:0] f;
      logic        cout_n;
      logic        eql;
      logic        zero;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_d;
   logic       strobe;
   logic       sel;
   logic       done_prev;
   int         n_cmp;
   int         n_err;
   exp_t       sb_q[$];

   always #5 clk = ~clk;

   alu_seq_if bus ();
   assign bus.ui_in  = ui_d;
   assign bus.uio_in = {6'b000000, sel, strobe};

   tt_um_guidoism_alu_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .ena   (ena),
      .bus   (bus)
   );

   // Behavioural reference for the functions exercised here (A plus B, A minus B minus 1, XOR)
   function automatic exp_t model(input logic [7:0] ctrl, input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [16:0] a17;
      logic [16:0] b17;
      logic [16:0] sum;
      logic        cin;
      cin = ~ctrl[5];
      a17 = {1'b0, a};
      b17 = (ctrl[3:0] == 4'h9) ? {1'b0, b} : {1'b0, ~b};
      sum = a17 + b17 + {16'h0000, cin};
      if (ctrl[4]) e.f = (ctrl[3:0] == 4'h6) ? (a ^ b) : 16'h0000;
      else         e.f = sum[15:0];
      e.cout_n = ~sum[16];
      e.eql    = &e.f;
      e.zero   = (e.f == 16'h0000);
      return e;
   endfunction

   // Scoreboard: every rising done pops one expected result
   initial done_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n === 1'b1 && bus.uio_out[3] === 1'b1 && !done_prev) begin
         n_cmp++;
         if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected_done: done rose with no expected result queued");
         end else begin
            e = sb_q.pop_front();
            if (bus.uo_out !== e.f[7:0]) begin
               n_err++;
               $display("FAIL result_lo: got %h want %h", bus.uo_out, e.f[7:0]);
            end
            n_cmp++;
            if (bus.uio_out[6:4] !== {e.zero, e.eql, e.cout_n}) begin
               n_err++;
               $display("FAIL flags zero/eql/cout_n: got %b want %b", bus.uio_out[6:4], {e.zero, e.eql, e.cout_n});
            end
            sel = 1'b1;
            #1;
            n_cmp++;
            if (bus.uo_out !== e.f[15:8]) begin
               n_err++;
               $display("FAIL result_hi: got %h want %h", bus.uo_out, e.f[15:8]);
            end
            sel = 1'b0;
         end
      end
      done_prev = (rst_n === 1'b1) && (bus.uio_out[3] === 1'b1);
   end

   task automatic send_byte(input logic [7:0] d);
      repeat (2) @(negedge clk);
      ui_d   = d;
      strobe = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      strobe = 1'b0;
   endtask

   task automatic send_op(input logic [7:0] ctrl, input logic [15:0] a, input logic [15:0] b);
      send_byte(ctrl);
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(b[7:0]);
      send_byte(b[15:8]);
   endtask

   task automatic wait_done(input string tag);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 12 && !got; k++) begin
         @(negedge clk);
         got = (bus.uio_out[3] === 1'b1);
      end
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL %s_timeout: done not seen within 12 cycles", tag);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      strobe = 1'b0;
      sel    = 1'b0;
      ui_d   = 8'h00;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.uo_out !== 8'h00) begin n_err++; $display("FAIL reset_uo_lo: got %h want 00", bus.uo_out); end
      n_cmp++;
      if (bus.uio_out !== 8'h00) begin n_err++; $display("FAIL reset_uio_out: got %h want 00", bus.uio_out); end
      n_cmp++;
      if (bus.uio_oe !== 8'h7C) begin n_err++; $display("FAIL reset_uio_oe: got %h want 7c", bus.uio_oe); end
      sel = 1'b1;
      #1;
      n_cmp++;
      if (bus.uo_out !== 8'h00) begin n_err++; $display("FAIL reset_uo_hi: got %h want 00", bus.uo_out); end
      sel   = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_add();
      sb_q.push_back(model(8'h29, 16'h1234, 16'h4321));
      send_op(8'h29, 16'h1234, 16'h4321);
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if (bus.uio_out[3:2] !== 2'b01) begin
            n_err++;
            $display("FAIL add_busy_cycle%0d: done/busy got %b want 01", k, bus.uio_out[3:2]);
         end
         @(negedge clk);
      end
      n_cmp++;
      if (bus.uio_out[3:2] !== 2'b01) begin n_err++; $display("FAIL add_busy_cycle3: done/busy got %b want 01", bus.uio_out[3:2]); end
      @(negedge clk);
      n_cmp++;
      if (bus.uio_out[3:2] !== 2'b10) begin n_err++; $display("FAIL add_done_edge: done/busy got %b want 10", bus.uio_out[3:2]); end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_carry_ripple();
      sb_q.push_back(model(8'h29, 16'hFFFF, 16'h0001));
      send_op(8'h29, 16'hFFFF, 16'h0001);
      wait_done("carry");
   endtask

   task automatic test_compare();
      sb_q.push_back(model(8'h26, 16'hBEEF, 16'hBEEF));
      send_op(8'h26, 16'hBEEF, 16'hBEEF);
      wait_done("cmp_eq");
      sb_q.push_back(model(8'h26, 16'hBEEF, 16'hBEEE));
      send_op(8'h26, 16'hBEEF, 16'hBEEE);
      wait_done("cmp_ne");
   endtask

   // A strobe edge lands while EXEC is on its last nibble and must be ignored
   task automatic test_exec_strobe();
      sb_q.push_back(model(8'h36, 16'hF0F0, 16'hFF00));
      send_byte(8'h36);
      send_byte(8'hF0);
      send_byte(8'hF0);
      send_byte(8'h00);
      repeat (2) @(negedge clk);
      ui_d   = 8'hFF;
      strobe = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      strobe = 1'b0;
      @(negedge clk);
      ui_d   = 8'h5A;
      strobe = 1'b1;
      wait_done("xor");
      strobe = 1'b0;
      sb_q.push_back(model(8'h29, 16'h0102, 16'h0304));
      send_op(8'h29, 16'h0102, 16'h0304);
      wait_done("after_xor");
   endtask

   task automatic test_reset_exec();
      send_op(8'h29, 16'hFFFF, 16'hFFFF);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bus.uo_out !== 8'h00) begin n_err++; $display("FAIL abort_uo_out: got %h want 00", bus.uo_out); end
      n_cmp++;
      if (bus.uio_out !== 8'h00) begin n_err++; $display("FAIL abort_uio_out: got %h want 00", bus.uio_out); end
      rst_n = 1'b1;
      sb_q.push_back(model(8'h29, 16'h0001, 16'h0001));
      send_op(8'h29, 16'h0001, 16'h0001);
      wait_done("after_abort");
   endtask

   task automatic test_ena_freeze();
      int cyc;
      sb_q.push_back(model(8'h29, 16'h00FF, 16'h0F01));
      send_byte(8'h29);
      send_byte(8'hFF);
      send_byte(8'h00);
      send_byte(8'h01);
      ena = 1'b0;
      send_byte(8'hAA);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (bus.uio_out[3:2] !== 2'b00) begin n_err++; $display("FAIL ena_drop_edge: done/busy got %b want 00", bus.uio_out[3:2]); end
      ena = 1'b1;
      send_byte(8'h0F);
      n_cmp++;
      if (bus.uio_out[3:2] !== 2'b01) begin n_err++; $display("FAIL ena_load_busy: done/busy got %b want 01", bus.uio_out[3:2]); end
      @(negedge clk);
      ena = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         n_cmp++;
         if (bus.uio_out[3:2] !== 2'b01) begin
            n_err++;
            $display("FAIL ena_frozen_cycle%0d: done/busy got %b want 01", k, bus.uio_out[3:2]);
         end
      end
      ena = 1'b1;
      cyc = 0;
      while (bus.uio_out[3] !== 1'b1 && cyc < 12) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (cyc != 3) begin n_err++; $display("FAIL ena_resume_cycles: got %0d want 3", cyc); end
      repeat (2) @(negedge clk);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      test_reset();
      test_add();
      test_carry_ripple();
      test_compare();
      test_exec_strobe();
      test_reset_exec();
      test_ena_freeze();
      n_cmp++;
      if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d pending want 0", sb_q.size()); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
